// File: rtl/exec_mem_stage_buffer_pkg.sv
// Shared pipeline definitions for the stage buffers.
// Holds the default field widths, the packed bundle layout (bit offsets)
// and the buffer state encoding. The state encoding equals the occupancy.
package exec_mem_stage_buffer_pkg;

  localparam int unsigned PIPE_DATA_W   = 16;
  localparam int unsigned PIPE_ADDR_W   = 4;
  localparam int unsigned PIPE_BUNDLE_W = 2*PIPE_DATA_W + PIPE_ADDR_W + 2;

  // Bundle layout, LSB first: data_read, reg_write, c_addr, result, data_val
  localparam int unsigned OFF_DATA_READ = 0;
  localparam int unsigned OFF_REG_WRITE = 1;
  localparam int unsigned OFF_C_ADDR    = 2;

  function automatic int unsigned bundle_w(int unsigned dw, int unsigned aw);
    return 2*dw + aw + 2;
  endfunction

  function automatic int unsigned off_result(int unsigned aw);
    return OFF_C_ADDR + aw;
  endfunction

  function automatic int unsigned off_data_val(int unsigned dw, int unsigned aw);
    return OFF_C_ADDR + aw + dw;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/exec_mem_stage_buffer_skid.sv
// stage_skid_buffer: generic 2-entry valid/ready pipeline register.
// Output is always driven from the main register; the skid register
// catches the one extra beat that arrives while downstream stalls.
// in_ready depends only on registered state (and RST), never on out_ready.
//
//   state    | meaning
//   ST_EMPTY | nothing buffered
//   ST_ONE   | main holds a beat, skid empty
//   ST_FULL  | main and skid both hold beats, upstream blocked
//
// Ports:
//   CLK        clock, state updates on the falling edge
//   RST        synchronous active-high reset
//   flush      drop all buffered beats and any beat presented this cycle
//   in_valid / in_ready / in_data     upstream handshake and payload
//   out_valid / out_ready / out_data  downstream handshake and payload
//   occupancy  number of buffered beats (0..2)
module stage_skid_buffer
  import exec_mem_stage_buffer_pkg::*;
#(
  parameter int unsigned W = PIPE_BUNDLE_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  buf_state_e   state, state_nxt;
  logic [W-1:0] main_q, main_nxt;
  logic [W-1:0] skid_q, skid_nxt;
  logic         in_fire, out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL) & ~RST;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state;

  always_ff @(negedge CLK) begin
    if (RST) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // data is kept so the outputs hold their last value
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end else if (in_fire) begin
            skid_nxt  = in_data;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_nxt  = skid_q;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/exec_mem_stage_buffer.sv
// exec_mem_stage_buffer: EX->MEM pipeline stage register.
// Packs the execute-stage fields into one bundle for the skid buffer,
// gates reg_write/data_read with out_valid so bubbles have no side effects,
// and counts stalled cycles in a saturating counter.
//
// Ports:
//   CLK, RST                       clock (falling-edge updates), sync reset
//   flush                          kill all buffered beats
//   in_valid, in_ready             upstream handshake
//   data_val_in, result_in, c_addr_in, reg_write_in, data_read_in  payload in
//   out_valid, out_ready           downstream handshake
//   data_val, result, c_addr, reg_write, data_read                 payload out
//   occupancy                      buffered beats (0..2)
//   stall_count                    cycles with out_valid=1 and out_ready=0
module exec_mem_stage_buffer
  import exec_mem_stage_buffer_pkg::*;
#(
  parameter int unsigned DATA_W  = PIPE_DATA_W,
  parameter int unsigned ADDR_W  = PIPE_ADDR_W,
  parameter int unsigned STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_val_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [ADDR_W-1:0]  c_addr_in,
  input  logic               reg_write_in,
  input  logic               data_read_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_val,
  output logic [DATA_W-1:0]  result,
  output logic [ADDR_W-1:0]  c_addr,
  output logic               reg_write,
  output logic               data_read,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_count
);

  localparam int unsigned BW      = bundle_w(DATA_W, ADDR_W);
  localparam int unsigned OFF_RES = off_result(ADDR_W);
  localparam int unsigned OFF_DV  = off_data_val(DATA_W, ADDR_W);

  logic [BW-1:0] in_bundle, out_bundle;

  assign in_bundle = {data_val_in, result_in, c_addr_in, reg_write_in, data_read_in};

  stage_skid_buffer #(.W(BW)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle),
    .occupancy (occupancy)
  );

  assign data_val  = out_bundle[OFF_DV +: DATA_W];
  assign result    = out_bundle[OFF_RES +: DATA_W];
  assign c_addr    = out_bundle[OFF_C_ADDR +: ADDR_W];
  assign reg_write = out_bundle[OFF_REG_WRITE] & out_valid;
  assign data_read = out_bundle[OFF_DATA_READ] & out_valid;

  always_ff @(negedge CLK) begin
    if (RST) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_mem_stage_buffer.sv
module tb_exec_mem_stage_buffer;

  typedef struct packed {
    logic [15:0] dv;
    logic [15:0] res;
    logic [3:0]  ca;
    logic        rw;
    logic        dr;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST, flush, in_valid, out_ready;
  logic [15:0] data_val_in, result_in;
  logic [3:0]  c_addr_in;
  logic        reg_write_in, data_read_in;

  logic        in_ready, out_valid, reg_write, data_read;
  logic [15:0] data_val, result, stall_count;
  logic [3:0]  c_addr;
  logic [1:0]  occupancy;

  logic        s_in_ready, s_out_valid, s_reg_write, s_data_read;
  logic [15:0] s_data_val, s_result;
  logic [3:0]  s_c_addr;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  beat_t shown;
  int    m_st16, m_st3;

  always #5 CLK = ~CLK;

  exec_mem_stage_buffer #(.DATA_W(16), .ADDR_W(4), .STALL_W(16)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data_val_in(data_val_in), .result_in(result_in), .c_addr_in(c_addr_in),
    .reg_write_in(reg_write_in), .data_read_in(data_read_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_val(data_val), .result(result),
    .c_addr(c_addr), .reg_write(reg_write), .data_read(data_read),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  exec_mem_stage_buffer #(.DATA_W(16), .ADDR_W(4), .STALL_W(3)) dut_s (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .data_val_in(data_val_in), .result_in(result_in), .c_addr_in(c_addr_in),
    .reg_write_in(reg_write_in), .data_read_in(data_read_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .data_val(s_data_val), .result(s_result),
    .c_addr(s_c_addr), .reg_write(s_reg_write), .data_read(s_data_read),
    .occupancy(s_occupancy), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a bounded FIFO of two beats; the visible fields are
  // the oldest beat, or the last visible beat when the FIFO is empty.
  task automatic model_update();
    bit    ov, rdy;
    beat_t cur;
    cur = '{dv: data_val_in, res: result_in, ca: c_addr_in, rw: reg_write_in, dr: data_read_in};
    if (RST) begin
      q.delete();
      shown  = '0;
      m_st16 = 0;
      m_st3  = 0;
    end else begin
      ov  = (q.size() != 0);
      rdy = (q.size() < 2);
      if (ov && !out_ready && !flush) begin
        if (m_st16 < 65535) m_st16++;
        if (m_st3 < 7) m_st3++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(cur);
      end
      if (q.size() != 0) shown = q[0];
    end
  endtask

  task automatic check_all();
    bit ov;
    ov = (q.size() != 0);
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, !RST && q.size() < 2);
    chk("occupancy", occupancy, q.size());
    chk("result", result, shown.res);
    chk("data_val", data_val, shown.dv);
    chk("c_addr", c_addr, shown.ca);
    chk("reg_write", reg_write, shown.rw & ov);
    chk("data_read", data_read, shown.dr & ov);
    chk("stall_count", stall_count, m_st16);
    chk("s_stall_count", s_stall_count, m_st3);
    chk("s_result", s_result, shown.res);
    chk("s_occupancy", s_occupancy, q.size());
  endtask

  // One clock: state updates at the falling edge, outputs checked at the
  // following rising edge; callers change inputs right after this returns.
  task automatic tick();
    @(negedge CLK);
    model_update();
    @(posedge CLK);
    check_all();
  endtask

  task automatic drive(input logic iv, input logic [15:0] res, input logic [3:0] ca,
                       input logic rw, input logic dr);
    in_valid     = iv;
    result_in    = res;
    data_val_in  = ~res;
    c_addr_in    = ca;
    reg_write_in = rw;
    data_read_in = dr;
  endtask

  initial begin
    int st_before;
    q.delete();
    shown = '0; m_st16 = 0; m_st3 = 0;
    RST = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 16'hAAAA, 4'd1, 1'b1, 1'b1);

    // reset
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall", stall_count, 0);
    RST = 1'b0;
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("rst_in_ready", in_ready, 1);

    // streaming
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 4'(i), 1'b0, 1'b0);
      tick();
      chk("stream_result", result, i);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occ", occupancy, 1);
    end
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 4'd3, 1'b1, 1'b1); tick();
    drive(1'b1, 16'h2222, 4'd5, 1'b0, 1'b1); tick();
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    drive(1'b1, 16'h3333, 4'd7, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("bp_stall", stall_count, 4);
    chk("bp_head", result, 16'h1111);
    out_ready = 1'b1;
    tick();
    chk("bp_b", result, 16'h2222);
    tick();
    chk("bp_c", result, 16'h3333);
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();

    // bubble gating
    drive(1'b1, 16'h1111, 4'd3, 1'b1, 1'b1); tick();
    chk("bub_rw_live", reg_write, 1);
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0); tick();
    chk("bub_ov", out_valid, 0);
    chk("bub_rw", reg_write, 0);
    chk("bub_dr", data_read, 0);
    chk("bub_res", result, 16'h1111);

    // flush in FULL
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 4'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 16'h6666, 4'd4, 1'b0, 1'b1); tick();
    chk("fl_occ_full", occupancy, 2);
    st_before = m_st16;
    flush = 1'b1;
    drive(1'b1, 16'h4444, 4'd9, 1'b1, 1'b1); tick();
    chk("fl_ov", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall", stall_count, st_before);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0); tick();
    chk("fl_no_d", result == 16'h4444, 0);

    // saturation on the 3-bit counter
    RST = 1'b1; tick(); RST = 1'b0;
    chk("sat_clear", s_stall_count, 0);
    out_ready = 1'b0;
    drive(1'b1, 16'h7777, 4'd6, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_7", s_stall_count, 7);
    chk("sat_16", stall_count, 10);
    out_ready = 1'b1; tick();
    chk("sat_hold", s_stall_count, 7);
    RST = 1'b1; tick();
    chk("sat_rst", s_stall_count, 0);
    RST = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      RST       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 1) == 1, 16'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_mem_stage_buffer.md
Name: exec_mem_stage_buffer

Overview:
- Parametrised EX→MEM pipeline stage register for the 16-bit core, with a valid/ready handshake, a 2-entry skid buffer, a flush input, and a saturating stall counter.
- Carries data_val, result, c_addr, reg_write and data_read from the execute stage to the memory stage.
- Supports backpressure from a multi-cycle memory stage without combinational ready paths.
- Bubbles never write the register file or read memory.

Parameters:
- DATA_W, 16, width of data_val and result.
- ADDR_W, 4, width of the register destination address c_addr.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  system clock; all state updates on the falling edge of CLK.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  kill all buffered beats (branch/exception).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  buffer can accept a beat.
- data_val_in  in  DATA_W  store data from execute.
- result_in  in  DATA_W  ALU result / memory address.
- c_addr_in  in  ADDR_W  destination register.
- reg_write_in  in  1  writeback enable.
- data_read_in  in  1  memory read enable.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  memory stage accepts beat.
- data_val  out  DATA_W  buffered store data.
- result  out  DATA_W  buffered result.
- c_addr  out  ADDR_W  buffered destination register.
- reg_write  out  1  buffered writeback enable, qualified by out_valid.
- data_read  out  1  buffered memory read enable, qualified by out_valid.
- occupancy  out  2  number of buffered beats: 0, 1 or 2.
- stall_count  out  STALL_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset is synchronous and active-high (RST). All registers update on the falling edge of CLK.
  - Reset values: main and skid valid = 0; all data fields = 0; stall_count = 0; occupancy = 0.
  - in_ready is forced 0 while RST=1. Reset has priority over flush and over the handshakes.
- Beat transfers:
  - in fire = in_valid & in_ready.
  - out fire = out_valid & out_ready.
  - Output ports are driven directly from the main register. The skid register holds a second beat.
  - in_ready = ~skid_valid & ~RST. This is registered state only; there is no path from out_ready to in_ready.
- State machine (one-hot or encoded):
  - EMPTY: in fire → load main, go to ONE.
  - ONE, in fire and out fire → main ← input, stay in ONE.
  - ONE, out fire only → go to EMPTY.
  - ONE, in fire only → skid ← input, go to FULL.
  - ONE, neither → hold.
  - FULL: in_ready = 0. Out fire → main ← skid, go to ONE; otherwise hold.
- Latency and throughput:
  - A beat accepted at edge N appears on the outputs after edge N (latency 1).
  - Sustained throughput is 1 beat per cycle when out_ready = 1.
  - Beats leave strictly in arrival order.
- Bubble rule:
  - reg_write = main.reg_write & out_valid; data_read = main.data_read & out_valid.
  - data_val, result and c_addr hold their last value when out_valid = 0.
- Flush:
  - At the edge where flush = 1, both valids clear and the state goes to EMPTY.
  - Any beat presented in that cycle is discarded, even if in_ready = 1.
  - stall_count is unaffected by flush.
- Stall counter:
  - Increments at each edge where out_valid & ~out_ready & ~flush & ~RST.
  - Saturates at 2^STALL_W − 1 with no wrap.
  - Cleared only by RST.
- occupancy: EMPTY = 0, ONE = 1, FULL = 2. The value 3 never occurs.

Decomposition:
- Shared package (pipeline defs):
  - Field width constants DATA_W and ADDR_W.
  - Bundle width constant = 2*DATA_W + ADDR_W + 2.
  - Field bit offsets inside the packed bundle.
  - Occupancy/state encodings.
- Sub-module stage_skid_buffer:
  - Generic over bundle width.
  - Owns the valid/ready FSM, the main and skid registers, flush, and occupancy.
- Top level:
  - Packs and unpacks the fields.
  - Applies the bubble qualification.
  - Holds the stall counter.
- The same sub-module is reused for the ID/EX and MEM/WB stages.

Test Plan:
- Reset: RST = 1 for 2 cycles with in_valid = 1 and reg_write_in = 1 → out_valid = 0, reg_write = 0, occupancy = 0, stall_count = 0. in_ready = 1 after the first edge with RST = 0.
- Streaming: out_ready = 1; result_in = 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles → the same values appear on result one edge later, in order. in_ready is never 0 and occupancy stays 1.
- Backpressure:
  - out_ready = 0; send A (result 0x1111, c_addr 3) then B (0x2222, c_addr 5) → occupancy = 2, in_ready = 0, C (0x3333) is held upstream.
  - Raise out_ready → A, B, C are emitted in order.
  - stall_count equals the number of stalled cycles, for example 4.
- Flush in FULL: FULL state, then flush = 1 with in_valid = 1 and D = 0x4444 → next edge out_valid = 0, occupancy = 0, in_ready = 1. D never appears on the outputs; stall_count is unchanged.
- Bubble gating: after A (reg_write_in = 1, data_read_in = 1) drains with no new input → out_valid = 0, reg_write = 0, data_read = 0, result still 0x1111.
- Saturation with STALL_W = 3: out_valid = 1 and out_ready = 0 for 10 cycles → stall_count = 7 and stays 7. Releasing out_ready does not clear it; RST does.
